fifo_reader: RTL
================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter width, default 16, data word width in bits.
REQ-002 SHALL have parameter depth, default 16, depth of the attached synchronous FIFO in words.
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to read a transfer; ignored unless busy=0.
REQ-006 SHALL have port xfer_len  input  $clog2(depth)+1  number of words to read, sampled when start is accepted.
REQ-007 SHALL have port fifo_read  output  1  pop strobe to the FIFO.
REQ-008 SHALL have port fifo_data_out  input  width  FIFO read data.
REQ-009 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-010 SHALL have port out_valid  output  1  downstream data valid.
REQ-011 SHALL have port out_data  output  width  downstream data.
REQ-012 SHALL have port out_ready  input  1  downstream accepts data when high together with out_valid.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the last word of a transfer is accepted downstream.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-016 SHALL go IDLE->RUN on start with xfer_len>0: latch len, clear issued and delivered counters, and set busy=1 in the next cycle.
REQ-017 SHALL, on start with xfer_len=0, stay in IDLE, keep busy=0, and pulse done for 1 cycle in the next cycle.
REQ-018 SHALL treat FIFO read data as valid on fifo_data_out exactly one cycle after the cycle in which fifo_read=1.
REQ-019 SHALL assert fifo_read only in RUN, only when fifo_empty=0, issued<len, and buffered+in_flight<2.
REQ-020 SHALL hold returned words in a 2-entry in-order output buffer; out_data SHALL be the oldest entry.
REQ-021 SHALL assert out_valid whenever the buffer is not empty, and hold out_data stable until out_ready=1.
REQ-022 SHALL allow an entry to be written and the head to be popped in the same cycle without a bubble; sustained throughput SHALL be 1 word/cycle when fifo_empty=0 and out_ready=1.
REQ-023 SHALL go RUN->FLUSH in the cycle issued reaches len.
REQ-024 SHALL go FLUSH->IDLE when the word with delivered=len-1 is accepted, pulsing done in that same cycle and clearing busy in the next cycle.
REQ-025 SHALL size counters $clog2(depth)+1 bits; counters SHALL never wrap within a transfer.
REQ-026 SHALL ignore start while busy=1; a transfer already latched SHALL be unaffected.
REQ-027 SHALL, when fifo_empty rises mid-transfer, stall issuing without dropping or duplicating words, and resume when fifo_empty=0.

Reset
REQ-028 SHALL, with rst_=0 at a clock edge, force IDLE, clear counters and buffer, and drive fifo_read=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-029 SHALL, on reset mid-transfer, discard in-flight and buffered words, and SHALL NOT pulse done.

Structure
REQ-030 SHALL take the FSM state enum and default width/depth constants from a shared package, fifo_pkg.
REQ-031 SHALL implement the 2-entry output buffer as sub-module fifo_reader_skid, with parameter width.

Verification
REQ-032 SHALL verify: FIFO preloaded with 7,8,9 and out_ready=1, start with xfer_len=3 -> out_data 7,8,9 on consecutive cycles, done with the 3rd word, busy=0 one cycle later.
REQ-033 SHALL verify: xfer_len=4 and out_ready=0 for 5 cycles -> exactly 2 fifo_read pulses, out_data holds the first word; after release, all 4 words arrive in order.
REQ-034 SHALL verify: FIFO holding 1 word, xfer_len=3, then 2 words pushed 4 cycles later -> fifo_read never high while fifo_empty=1, and 3 words are delivered in order.
REQ-035 SHALL verify: start with xfer_len=0 -> done pulse with no fifo_read, and busy stays 0.
REQ-036 SHALL verify: rst_=0 after the 2nd word of a 5-word transfer -> all outputs 0 the next cycle, no done pulse, and a fresh start works.
REQ-037 SHALL verify: start pulsed while busy=1 -> ignored, and the original len completes.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader: default sizing and FSM state encoding.
package fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer. Head entry drives the downstream data.
// A push and a pop may happen in the same cycle.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head_data,
    output logic [1:0]       count
);

    logic [width-1:0] ent0_q;
    logic [width-1:0] ent1_q;

    assign head_data = ent0_q;

    // Entry storage and occupancy; ent0 is always the oldest word.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            ent0_q <= '0;
            ent1_q <= '0;
            count  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) ent0_q <= push_data;
                    else               ent1_q <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0_q <= push_data;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Reads a requested number of words from a synchronous FIFO (one-cycle read
// latency) and hands them downstream through a 2-entry buffer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; zero-length start only pulses done
//   ST_RUN   | issuing FIFO pops until issued reaches len
//   ST_FLUSH | all pops issued; draining until the last word is accepted
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     start,
    input  logic [$clog2(depth):0]   xfer_len,
    output logic                     fifo_read,
    input  logic [width-1:0]         fifo_data_out,
    input  logic                     fifo_empty,
    output logic                     out_valid,
    output logic [width-1:0]         out_data,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(depth) + 1;

    rd_state_t       state_q, state_d;
    logic [CW-1:0]   len_q, issued_q, delivered_q;
    logic            in_flight_q;
    logic            zero_done_q;
    logic [1:0]      buf_count;
    logic            pop;
    logic            last_accept;
    logic [2:0]      occ_after_pop;
    logic            accept_start;

    assign out_valid    = (buf_count != 2'd0);
    assign pop          = out_valid & out_ready;
    assign busy         = (state_q != ST_IDLE);
    assign done         = last_accept | zero_done_q;
    assign accept_start = (state_q == ST_IDLE) && start;

    fifo_reader_skid #(.width(width)) u_skid (
        .clk       (clk),
        .rst_      (rst_),
        .push      (in_flight_q),
        .push_data (fifo_data_out),
        .pop       (pop),
        .head_data (out_data),
        .count     (buf_count)
    );

    // Next-state and pop-strobe decode. Occupancy is counted after this
    // cycle's downstream pop so a full pipeline still issues every cycle.
    always_comb begin
        state_d       = state_q;
        fifo_read     = 1'b0;
        last_accept   = 1'b0;
        occ_after_pop = 3'(buf_count) - 3'(pop) + 3'(in_flight_q);
        case (state_q)
            ST_IDLE: begin
                if (start && (xfer_len != '0)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!fifo_empty && (issued_q < len_q) && (occ_after_pop < 3'd2)) begin
                    fifo_read = 1'b1;
                    if ((issued_q + CW'(1)) == len_q) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (pop && (delivered_q == (len_q - CW'(1)))) begin
                    last_accept = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, transfer counters and read-latency tracking.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            in_flight_q <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= fifo_read;
            zero_done_q <= accept_start && (xfer_len == '0);
            if (accept_start && (xfer_len != '0)) begin
                len_q       <= xfer_len;
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (fifo_read) issued_q <= issued_q + CW'(1);
                if (pop && busy) delivered_q <= delivered_q + CW'(1);
            end
        end
    end

endmodule
